multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the port `clk_i`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_i`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port `instr_op_i`, input, 6 bits: opcode from the instruction register.
REQ-004 The block SHALL have the port `funct_i`, input, 6 bits: funct field from the instruction register.
REQ-005 The block SHALL have the port `mem_ready_i`, input, 1 bit: the shared memory has completed the current access this cycle.
REQ-006 The block SHALL have the ports `mem_read_o`, `mem_write_o`, `IorD_o`, `IRWrite_o`, `PCWrite_o`, `PCWriteCond_o`, `RegWrite_o` and `ALUSrcA_o`, each output, 1 bit: datapath strobes and mux selects.
REQ-007 The block SHALL have the ports `ALUSrcB_o`, `ALUOp_o`, `PCSource_o`, `RegDst_o` and `RegWriteSrc_o`, each output, 2 bits: datapath mux selects and ALU class.
REQ-008 The block SHALL have the port `illegal_o`, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-009 The block SHALL have the port `state_o`, output, 4 bits: current state encoding (debug).

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, JR.
REQ-011 The FSM SHALL make these transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE when `mem_ready_i`=1; otherwise stay in FETCH.
REQ-012 DECODE SHALL dispatch on opcode:
  - 100011/101011→MEMADR
  - 000000 with funct 001000→JR
  - 000000 otherwise→EXEC_R
  - 001000/001010→EXEC_I
  - 000100→BRANCH
  - 000010/000011→JUMP
  - any other opcode→FETCH, with `illegal_o`=1 for that DECODE cycle.
REQ-013 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-014 MEMRD SHALL go to MEMWB only when `mem_ready_i`=1; MEMWR SHALL go to FETCH only when `mem_ready_i`=1; both SHALL hold otherwise.
REQ-015 EXEC_R→RWB, EXEC_I→IWB, then MEMWB/RWB/IWB/BRANCH/JUMP/JR→FETCH, each in exactly one cycle.
REQ-016 In FETCH the block SHALL drive `mem_read_o`=1, `IorD_o`=0, `ALUSrcA_o`=0, `ALUSrcB_o`=01, `ALUOp_o`=00 and `PCSource_o`=00.
REQ-017 In FETCH, `IRWrite_o` and `PCWrite_o` SHALL equal `mem_ready_i` (the only Mealy outputs).
REQ-018 In DECODE the block SHALL drive `ALUSrcA_o`=0, `ALUSrcB_o`=11 and `ALUOp_o`=00 (branch target).
REQ-019 In MEMADR the block SHALL drive `ALUSrcA_o`=1, `ALUSrcB_o`=10 and `ALUOp_o`=00.
REQ-020 In MEMRD the block SHALL drive `mem_read_o`=1 and `IorD_o`=1; in MEMWR it SHALL drive `mem_write_o`=1 and `IorD_o`=1.
REQ-021 In MEMWB the block SHALL drive `RegWrite_o`=1, `RegDst_o`=00 and `RegWriteSrc_o`=01.
REQ-022 In EXEC_R the block SHALL drive `ALUSrcA_o`=1, `ALUSrcB_o`=00 and `ALUOp_o`=10 (funct).
REQ-023 In RWB the block SHALL drive `RegWrite_o`=1, `RegDst_o`=01 and `RegWriteSrc_o`=00.
REQ-024 In EXEC_I the block SHALL drive `ALUSrcA_o`=1 and `ALUSrcB_o`=10, with `ALUOp_o`=00 for addi and 11 for slti.
REQ-025 In IWB the block SHALL drive `RegWrite_o`=1, `RegDst_o`=00 and `RegWriteSrc_o`=00.
REQ-026 In BRANCH the block SHALL drive `ALUSrcA_o`=1, `ALUSrcB_o`=00, `ALUOp_o`=01, `PCWriteCond_o`=1 and `PCSource_o`=01.
REQ-027 In JUMP the block SHALL drive `PCWrite_o`=1 and `PCSource_o`=10; for jal it SHALL additionally drive `RegWrite_o`=1, `RegDst_o`=10 and `RegWriteSrc_o`=10.
REQ-028 In JR the block SHALL drive `PCWrite_o`=1 and `PCSource_o`=11.
REQ-029 Every output not listed for a state SHALL be 0 in that state; IDLE drives all outputs 0.
REQ-030 `mem_read_o` and `mem_write_o` SHALL never both be 1, and SHALL stay asserted unchanged until `mem_ready_i` is seen.
REQ-031 `instr_op_i` and `funct_i` SHALL be sampled only in DECODE, EXEC_I and JUMP; the register they come from is stable after FETCH.

Reset
REQ-032 When `rst_i`=1 the FSM SHALL go to IDLE asynchronously, and all outputs SHALL be 0 within the same cycle, including mid-access.
REQ-033 No strobe SHALL be generated on the clock edge where `rst_i` deasserts.
REQ-034 FETCH SHALL start exactly one cycle after reset release.

Structure
REQ-035 The package `mips_ctrl_pkg` SHALL hold the state enum, the opcode and funct constants, and the `ALUOp`/`PCSource`/`RegDst`/`RegWriteSrc` encodings.
REQ-036 The block SHALL be a single module, with no sub-module: one sequential state register and combinational next-state/output blocks.

Verification
REQ-037 The bench SHALL check: reset, release, `mem_ready_i`=1 held → IDLE, FETCH, DECODE, with `IRWrite_o`=1 exactly once.
REQ-038 The bench SHALL check: lw (op 100011) with `mem_ready_i` low 3 cycles in MEMRD → `mem_read_o`=`IorD_o`=1 held 4 cycles, then MEMWB with `RegWrite_o`=1 and `RegWriteSrc_o`=01; total 5 states plus 3 waits.
REQ-039 The bench SHALL check: R-type add (op 0, funct 100000) → EXEC_R with `ALUOp_o`=10, then RWB with `RegDst_o`=01; jr (funct 001000) → JR with `PCSource_o`=11 and `RegWrite_o`=0.
REQ-040 The bench SHALL check: beq (000100) → BRANCH with `PCWriteCond_o`=1, `ALUOp_o`=01 and `PCWrite_o`=0; jal (000011) → JUMP with `PCWrite_o`=1, `RegDst_o`=10 and `RegWriteSrc_o`=10.
REQ-041 The bench SHALL check: op 111111 → `illegal_o` pulses 1 cycle and the FSM returns to FETCH with no `RegWrite_o`/`mem_write_o`.
REQ-042 The bench SHALL check: `rst_i` asserted while in MEMWR with `mem_write_o`=1 → `mem_write_o`=0 immediately and `state_o`=IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state enum, opcode/funct constants and the datapath select encodings.
// No logic; imported by multicycle_ctrl.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC_R = 4'd7,
      S_RWB    = 4'd8,
      S_EXEC_I = 4'd9,
      S_IWB    = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_JR     = 4'd13
   } state_t;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // Funct codes
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   // Next-PC source
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   // Register-file destination select
   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   // Register-file write-data source
   localparam logic [1:0] WBSRC_ALU = 2'b00;
   localparam logic [1:0] WBSRC_MEM = 2'b01;
   localparam logic [1:0] WBSRC_PC  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM driving datapath strobes and mux selects.
// Latency: 3-5 states per instruction plus one per memory wait cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold with their access strobes steady until mem_ready_i.
//
// Ports: clk_i/rst_i (async active-high); instr_op_i/funct_i from the IR;
// mem_ready_i ends the current memory access; *_o are datapath controls,
// illegal_o flags an unsupported opcode in DECODE, state_o exposes the state.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic [5:0] funct_i,
   input  logic       mem_ready_i,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       IorD_o,
   output logic       IRWrite_o,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUOp_o,
   output logic [1:0] PCSource_o,
   output logic [1:0] RegDst_o,
   output logic [1:0] RegWriteSrc_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   state_t state;
   state_t nextState;
   // lw/sw choice latched in DECODE so MEMADR need not look at the opcode.
   logic   isStore;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         isStore <= 1'b0;
      end else begin
         state <= nextState;
         if (state == S_DECODE) begin
            isStore <= (instr_op_i == OP_SW);
         end
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         S_IDLE:   nextState = S_FETCH;
         S_FETCH:  nextState = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (instr_op_i)
               OP_LW, OP_SW:     nextState = S_MEMADR;
               OP_RTYPE:         nextState = (funct_i == FUNCT_JR) ? S_JR : S_EXEC_R;
               OP_ADDI, OP_SLTI: nextState = S_EXEC_I;
               OP_BEQ:           nextState = S_BRANCH;
               OP_J, OP_JAL:     nextState = S_JUMP;
               default:          nextState = S_FETCH;
            endcase
         end
         S_MEMADR: nextState = isStore ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nextState = mem_ready_i ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nextState = mem_ready_i ? S_FETCH : S_MEMWR;
         S_EXEC_R: nextState = S_RWB;
         S_EXEC_I: nextState = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR: nextState = S_FETCH;
         default:  nextState = S_IDLE;
      endcase
   end

   // Outputs decode from the state register alone, so an asynchronous reset
   // clears them in the same cycle; only FETCH looks at mem_ready_i.
   always_comb begin
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      IorD_o        = 1'b0;
      IRWrite_o     = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_REG;
      ALUOp_o       = ALUOP_ADD;
      PCSource_o    = PCSRC_ALU;
      RegDst_o      = REGDST_RT;
      RegWriteSrc_o = WBSRC_ALU;
      illegal_o     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read_o = 1'b1;
            ALUSrcB_o  = SRCB_FOUR;
            IRWrite_o  = mem_ready_i;
            PCWrite_o  = mem_ready_i;
         end
         S_DECODE: begin
            ALUSrcB_o = SRCB_BRANCH;
            case (instr_op_i)
               OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_SLTI,
               OP_BEQ, OP_J, OP_JAL: illegal_o = 1'b0;
               default:              illegal_o = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read_o = 1'b1;
            IorD_o     = 1'b1;
         end
         S_MEMWR: begin
            mem_write_o = 1'b1;
            IorD_o      = 1'b1;
         end
         S_MEMWB: begin
            RegWrite_o    = 1'b1;
            RegWriteSrc_o = WBSRC_MEM;
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            ALUOp_o   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegWrite_o = 1'b1;
            RegDst_o   = REGDST_RD;
         end
         S_EXEC_I: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_IMM;
            ALUOp_o   = (instr_op_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
         end
         S_IWB: RegWrite_o = 1'b1;
         S_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUOp_o       = ALUOP_SUB;
            PCWriteCond_o = 1'b1;
            PCSource_o    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = PCSRC_JUMP;
            if (instr_op_i == OP_JAL) begin
               RegWrite_o    = 1'b1;
               RegDst_o      = REGDST_RA;
               RegWriteSrc_o = WBSRC_PC;
            end
         end
         S_JR: begin
            PCWrite_o  = 1'b1;
            PCSource_o = PCSRC_REG;
         end
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cycle table, random instruction stream
// against an instruction-level model, and reset during a memory write.
module tb_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] instr_op_i;
   logic [5:0] funct_i;
   logic       mem_ready_i;
   logic       mem_read_o, mem_write_o, IorD_o, IRWrite_o, PCWrite_o;
   logic       PCWriteCond_o, RegWrite_o, ALUSrcA_o;
   logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o, RegDst_o, RegWriteSrc_o;
   logic       illegal_o;
   logic [3:0] state_o;

   multicycle_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
      .mem_ready_i(mem_ready_i), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .IorD_o(IorD_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
      .PCWriteCond_o(PCWriteCond_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
      .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o), .PCSource_o(PCSource_o),
      .RegDst_o(RegDst_o), .RegWriteSrc_o(RegWriteSrc_o), .illegal_o(illegal_o),
      .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   // Strobes: {memRead, memWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite, ALUSrcA}
   // Selects: {ALUSrcB, ALUOp, PCSource, RegDst, RegWriteSrc}
   logic [22:0] act;
   assign act = {mem_read_o, mem_write_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
                 RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, RegDst_o,
                 RegWriteSrc_o, illegal_o, state_o};

   int errors = 0;
   int checks = 0;

   function automatic logic [22:0] ex(state_t st, logic [7:0] str, logic [9:0] sel, logic ill);
      return {str, sel, ill, st};
   endfunction

   task automatic check(string name, int idx, logic [22:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got str=%b sel=%b ill=%b st=%0d, want str=%b sel=%b ill=%b st=%0d",
                  name, idx, act[22:15], act[14:5], act[4], act[3:0],
                  exp[22:15], exp[14:5], exp[4], exp[3:0]);
      end
   endtask

   task automatic step(logic rdy, logic [5:0] op, logic [5:0] fn, logic [22:0] exp,
                       string name, int idx);
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      mem_ready_i = rdy;
      instr_op_i  = op;
      funct_i     = fn;
      @(negedge clk_i);
      check(name, idx, exp);
   endtask

   typedef struct {
      logic        rdy;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [22:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(logic rdy, logic [5:0] op, logic [5:0] fn, logic [22:0] exp);
      vec_t v;
      v.rdy = rdy; v.op = op; v.fn = fn; v.exp = exp;
      return v;
   endfunction

   // Instruction-level reference model: expands one instruction into the
   // per-cycle ready pattern and expected control outputs.
   logic        qRdy[$];
   logic [5:0]  qOp[$];
   logic [5:0]  qFn[$];
   logic [22:0] qExp[$];

   task automatic push(logic rdy, logic [5:0] op, logic [5:0] fn, logic [22:0] exp);
      qRdy.push_back(rdy); qOp.push_back(op); qFn.push_back(fn); qExp.push_back(exp);
   endtask

   task automatic expand(logic [5:0] op, logic [5:0] fn, int fw, int mw);
      logic isLw, isSw, isR, isI, isBeq, isJmp, legal;
      isLw  = (op == 6'b100011);
      isSw  = (op == 6'b101011);
      isR   = (op == 6'b000000);
      isI   = (op == 6'b001000) || (op == 6'b001010);
      isBeq = (op == 6'b000100);
      isJmp = (op == 6'b000010) || (op == 6'b000011);
      legal = isLw || isSw || isR || isI || isBeq || isJmp;
      for (int k = 0; k < fw; k++) push(1'b0, op, fn, ex(S_FETCH, 8'b1000_0000, 10'b01_00_00_00_00, 1'b0));
      push(1'b1, op, fn, ex(S_FETCH, 8'b1001_1000, 10'b01_00_00_00_00, 1'b0));
      push(1'($urandom), op, fn, ex(S_DECODE, 8'b0, 10'b11_00_00_00_00, !legal));
      if (isLw || isSw) begin
         push(1'($urandom), op, fn, ex(S_MEMADR, 8'b0000_0001, 10'b10_00_00_00_00, 1'b0));
         for (int k = 0; k <= mw; k++)
            push(k == mw, op, fn, isLw ? ex(S_MEMRD, 8'b1010_0000, 10'b0, 1'b0)
                                       : ex(S_MEMWR, 8'b0110_0000, 10'b0, 1'b0));
         if (isLw) push(1'($urandom), op, fn, ex(S_MEMWB, 8'b0000_0010, 10'b00_00_00_00_01, 1'b0));
      end else if (isR && fn == 6'b001000) begin
         push(1'($urandom), op, fn, ex(S_JR, 8'b0000_1000, 10'b00_00_11_00_00, 1'b0));
      end else if (isR) begin
         push(1'($urandom), op, fn, ex(S_EXEC_R, 8'b0000_0001, 10'b00_10_00_00_00, 1'b0));
         push(1'($urandom), op, fn, ex(S_RWB, 8'b0000_0010, 10'b00_00_00_01_00, 1'b0));
      end else if (isI) begin
         push(1'($urandom), op, fn, ex(S_EXEC_I, 8'b0000_0001,
              (op == 6'b001010) ? 10'b10_11_00_00_00 : 10'b10_00_00_00_00, 1'b0));
         push(1'($urandom), op, fn, ex(S_IWB, 8'b0000_0010, 10'b0, 1'b0));
      end else if (isBeq) begin
         push(1'($urandom), op, fn, ex(S_BRANCH, 8'b0000_0101, 10'b00_01_01_00_00, 1'b0));
      end else if (isJmp) begin
         push(1'($urandom), op, fn, (op == 6'b000011)
              ? ex(S_JUMP, 8'b0000_1010, 10'b00_00_10_10_10, 1'b0)
              : ex(S_JUMP, 8'b0000_1000, 10'b00_00_10_00_00, 1'b0));
      end
   endtask

   logic [5:0] opList[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001000,
                              6'b001010, 6'b000100, 6'b000010, 6'b000011, 6'b111111};

   initial begin
      logic [22:0] zero, f1, f0, dc;
      logic [5:0]  op, fn;
      int          idx;
      zero = ex(S_IDLE, 8'b0, 10'b0, 1'b0);
      f1   = ex(S_FETCH, 8'b1001_1000, 10'b01_00_00_00_00, 1'b0);
      f0   = ex(S_FETCH, 8'b1000_0000, 10'b01_00_00_00_00, 1'b0);
      dc   = ex(S_DECODE, 8'b0, 10'b11_00_00_00_00, 1'b0);

      // Directed sequence: release, lw with 3 waits, add, jr, beq, jal,
      // illegal op, addi, slti, j.
      tbl.push_back(mkv(1, 6'b000000, 6'b0, zero));
      tbl.push_back(mkv(1, 6'b100011, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b100011, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b100011, 6'b0, ex(S_MEMADR, 8'b0000_0001, 10'b10_00_00_00_00, 0)));
      for (int k = 0; k < 3; k++) tbl.push_back(mkv(0, 6'b100011, 6'b0, ex(S_MEMRD, 8'b1010_0000, 10'b0, 0)));
      tbl.push_back(mkv(1, 6'b100011, 6'b0, ex(S_MEMRD, 8'b1010_0000, 10'b0, 0)));
      tbl.push_back(mkv(1, 6'b100011, 6'b0, ex(S_MEMWB, 8'b0000_0010, 10'b00_00_00_00_01, 0)));
      tbl.push_back(mkv(1, 6'b000000, 6'b100000, f1));
      tbl.push_back(mkv(1, 6'b000000, 6'b100000, dc));
      tbl.push_back(mkv(1, 6'b000000, 6'b100000, ex(S_EXEC_R, 8'b0000_0001, 10'b00_10_00_00_00, 0)));
      tbl.push_back(mkv(1, 6'b000000, 6'b100000, ex(S_RWB, 8'b0000_0010, 10'b00_00_00_01_00, 0)));
      tbl.push_back(mkv(1, 6'b000000, 6'b001000, f1));
      tbl.push_back(mkv(1, 6'b000000, 6'b001000, dc));
      tbl.push_back(mkv(1, 6'b000000, 6'b001000, ex(S_JR, 8'b0000_1000, 10'b00_00_11_00_00, 0)));
      tbl.push_back(mkv(1, 6'b000100, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b000100, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b000100, 6'b0, ex(S_BRANCH, 8'b0000_0101, 10'b00_01_01_00_00, 0)));
      tbl.push_back(mkv(1, 6'b000011, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b000011, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b000011, 6'b0, ex(S_JUMP, 8'b0000_1010, 10'b00_00_10_10_10, 0)));
      tbl.push_back(mkv(1, 6'b111111, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b111111, 6'b0, ex(S_DECODE, 8'b0, 10'b11_00_00_00_00, 1)));
      tbl.push_back(mkv(0, 6'b111111, 6'b0, f0));
      tbl.push_back(mkv(1, 6'b001000, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b001000, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b001000, 6'b0, ex(S_EXEC_I, 8'b0000_0001, 10'b10_00_00_00_00, 0)));
      tbl.push_back(mkv(1, 6'b001000, 6'b0, ex(S_IWB, 8'b0000_0010, 10'b0, 0)));
      tbl.push_back(mkv(1, 6'b001010, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b001010, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b001010, 6'b0, ex(S_EXEC_I, 8'b0000_0001, 10'b10_11_00_00_00, 0)));
      tbl.push_back(mkv(1, 6'b001010, 6'b0, ex(S_IWB, 8'b0000_0010, 10'b0, 0)));
      tbl.push_back(mkv(1, 6'b000010, 6'b0, f1));
      tbl.push_back(mkv(1, 6'b000010, 6'b0, dc));
      tbl.push_back(mkv(1, 6'b000010, 6'b0, ex(S_JUMP, 8'b0000_1000, 10'b00_00_10_00_00, 0)));

      rst_i       = 1'b1;
      mem_ready_i = 1'b1;
      instr_op_i  = 6'b0;
      funct_i     = 6'b0;
      #12;
      check("reset", 0, zero);
      @(negedge clk_i);

      foreach (tbl[i]) step(tbl[i].rdy, tbl[i].op, tbl[i].fn, tbl[i].exp, "table", i);

      // Random instruction stream against the model.
      idx = 0;
      for (int n = 0; n < 80; n++) begin
         op = opList[$urandom_range(0, 9)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         fn = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'($urandom);
         expand(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
         while (qExp.size() > 0) begin
            step(qRdy.pop_front(), qOp.pop_front(), qFn.pop_front(), qExp.pop_front(), "random", idx);
            idx++;
         end
      end

      // Reset asserted mid-cycle while a store is waiting on memory.
      step(1, 6'b101011, 6'b0, f1, "sw_rst", 0);
      step(1, 6'b101011, 6'b0, dc, "sw_rst", 1);
      step(1, 6'b101011, 6'b0, ex(S_MEMADR, 8'b0000_0001, 10'b10_00_00_00_00, 0), "sw_rst", 2);
      step(0, 6'b101011, 6'b0, ex(S_MEMWR, 8'b0110_0000, 10'b0, 0), "sw_rst", 3);
      #2;
      rst_i = 1'b1;
      #1;
      check("async_rst", 0, zero);
      step(1, 6'b100011, 6'b0, zero, "release", 0);
      step(1, 6'b100011, 6'b0, f1, "release", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
